// File: rtl/fix_rx_parser.sv
// fix_rx_parser: receive-side FIX tag=value parser.
//   Consumes one inbound byte per cycle, delimits messages, validates framing,
//   BodyLength(9) and (optionally) CheckSum(10), extracts MsgType(35) and
//   MsgSeqNum(34), and emits a 3-bit message-type code.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_i[7:0]       inbound byte, qualified by data_valid_i (no backpressure)
//   msg_valid_o       1-cycle pulse, complete valid message received
//   msg_type_o[2:0]   type code of last valid message (held)
//   seq_num_o         MsgSeqNum of last valid message (held, 0 if absent)
//   msg_error_o       1-cycle pulse, message rejected
//   err_code_o[2:0]   reject reason, valid with msg_error_o
// Optional feature: define FIX_RX_CHECKSUM_EN to build the checksum
//   accumulator and compare it against the tag-10 value.
module fix_rx_parser #(
  parameter int BODYLEN_W      = 16,
  parameter int SEQ_W          = 32,
  parameter int MAX_TAG_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic             msg_valid_o,
  output logic [2:0]       msg_type_o,
  output logic [SEQ_W-1:0] seq_num_o,
  output logic             msg_error_o,
  output logic [2:0]       err_code_o
);
  localparam int TAG_W = $clog2(10**MAX_TAG_DIGITS) + 1;
  localparam int TX    = TAG_W + 4;
  localparam int TD_W  = $clog2(MAX_TAG_DIGITS + 1) + 1;
  localparam int VAL_W = (SEQ_W > BODYLEN_W) ? SEQ_W : BODYLEN_W;
  localparam int VX    = VAL_W + 4;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ  = 8'h3D;

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_VALUE, S_RESYNC} state_t;

  state_t               r_state, w_state_nxt;
  logic [TAG_W-1:0]     r_tag;
  logic [TD_W-1:0]      r_tag_dig;
  logic [1:0]           r_fidx;      // field index, saturates at 3
  logic [BODYLEN_W-1:0] r_body_cnt, r_body_fs, r_body_len, w_body_nxt;
  logic [VAL_W-1:0]     r_val_num;
  logic [2:0]           r_vlen;      // value length, saturates at 7
  logic [7:0]           r_vfirst;
  logic                 r_nondig, r_ovf_b, r_ovf_s;
  logic [2:0]           r_type_cur, w_type;
  logic [SEQ_W-1:0]     r_seq_cur;
  logic                 r_msg_valid, r_msg_err;
  logic [2:0]           r_err_code, r_msg_type;
  logic [SEQ_W-1:0]     r_seq;
  logic                 w_err, w_done, w_start, w_fend, w_to_val, w_ck_ok;
  logic [2:0]           w_code;
  logic                 w_is_dig, w_t9, w_t10, w_t34, w_t35;
  logic [TX-1:0]        w_tag_nxt;
  logic [VX-1:0]        w_val_nxt;

  assign w_is_dig  = (data_i >= 8'h30) && (data_i <= 8'h39);
  assign w_t9      = (r_tag == TAG_W'(9));
  assign w_t10     = (r_tag == TAG_W'(10));
  assign w_t34     = (r_tag == TAG_W'(34));
  assign w_t35     = (r_tag == TAG_W'(35));
  assign w_tag_nxt = TX'(r_tag) * TX'(10) + TX'(data_i[3:0]);
  assign w_val_nxt = VX'(r_val_num) * VX'(10) + VX'(data_i[3:0]);
  // body bytes start right after the SOH closing tag 9 (field index 1)
  assign w_body_nxt = (r_fidx >= 2'd2 && (r_state == S_TAG || r_state == S_VALUE))
                      ? r_body_cnt + BODYLEN_W'(1) : r_body_cnt;

`ifdef FIX_RX_CHECKSUM_EN
  logic [7:0] r_sum, r_sum_fs;
  assign w_ck_ok = (r_val_num == VAL_W'(r_sum_fs));
`else
  assign w_ck_ok = 1'b1;
`endif

  always_comb begin
    w_type = 3'd7;
    if (r_vlen == 3'd1) begin
      case (r_vfirst)
        "A":     w_type = 3'd1;
        "0":     w_type = 3'd2;
        "1":     w_type = 3'd3;
        "2":     w_type = 3'd4;
        "3":     w_type = 3'd5;
        "5":     w_type = 3'd6;
        default: w_type = 3'd7;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_code      = 3'd0;
    w_done      = 1'b0;
    w_start     = 1'b0;
    w_fend      = 1'b0;
    w_to_val    = 1'b0;
    if (data_valid_i) begin
      case (r_state)
        S_IDLE: if (data_i == "8") begin
          w_start     = 1'b1;
          w_state_nxt = S_TAG;
        end
        S_TAG: begin
          if (w_is_dig) begin
            if (r_tag_dig == TD_W'(MAX_TAG_DIGITS)) begin w_err = 1'b1; w_code = 3'd7; end
          end else if (data_i == EQ) begin
            if (r_tag_dig == '0)                             begin w_err = 1'b1; w_code = 3'd6; end
            else if (r_fidx == 2'd0 && r_tag != TAG_W'(8))   begin w_err = 1'b1; w_code = 3'd1; end
            else if (r_fidx == 2'd1 && !w_t9)                begin w_err = 1'b1; w_code = 3'd2; end
            else if (r_fidx == 2'd2 && !w_t35)               begin w_err = 1'b1; w_code = 3'd3; end
            else w_to_val = 1'b1;
          end else begin
            w_err = 1'b1; w_code = 3'd6;
          end
          if (w_err)         w_state_nxt = (data_i == SOH) ? S_IDLE : S_RESYNC;
          else if (w_to_val) w_state_nxt = S_VALUE;
        end
        S_VALUE: if (data_i == SOH) begin
          if (r_vlen == 3'd0) begin w_err = 1'b1; w_code = 3'd6; end
          else if (w_t10) begin
            // length mismatch outranks format, which outranks checksum
            if (r_body_fs != r_body_len)            begin w_err = 1'b1; w_code = 3'd4; end
            else if (r_nondig || r_vlen != 3'd3)    begin w_err = 1'b1; w_code = 3'd6; end
            else if (!w_ck_ok)                      begin w_err = 1'b1; w_code = 3'd5; end
            else w_done = 1'b1;
          end
          else if ((w_t9 || w_t34) && r_nondig) begin w_err = 1'b1; w_code = 3'd6; end
          else if (w_t9 && r_ovf_b)             begin w_err = 1'b1; w_code = 3'd7; end
          else if (w_t34 && r_ovf_s)            begin w_err = 1'b1; w_code = 3'd7; end
          else w_fend = 1'b1;
          w_state_nxt = (w_err || w_done) ? S_IDLE : S_TAG;
        end
        S_RESYNC: if (data_i == SOH) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0; r_tag_dig <= '0; r_fidx <= '0;
      r_body_cnt <= '0; r_body_fs <= '0; r_body_len <= '0;
      r_val_num <= '0; r_vlen <= '0; r_vfirst <= '0;
      r_nondig <= 1'b0; r_ovf_b <= 1'b0; r_ovf_s <= 1'b0;
      r_type_cur <= '0; r_seq_cur <= '0;
      r_msg_valid <= 1'b0; r_msg_err <= 1'b0; r_err_code <= '0;
      r_msg_type <= '0; r_seq <= '0;
`ifdef FIX_RX_CHECKSUM_EN
      r_sum <= '0; r_sum_fs <= '0;
`endif
    end else begin
      r_msg_valid <= w_done;
      r_msg_err   <= w_err;
      r_err_code  <= w_err ? w_code : 3'd0;
      if (w_done) begin
        r_msg_type <= r_type_cur;
        r_seq      <= r_seq_cur;
      end
      if (data_valid_i) begin
`ifdef FIX_RX_CHECKSUM_EN
        r_sum <= w_start ? data_i : r_sum + data_i;
        if (w_fend) r_sum_fs <= r_sum + data_i;
`endif
        r_body_cnt <= w_start ? '0 : w_body_nxt;
        if (w_start) begin
          r_tag      <= TAG_W'(8);
          r_tag_dig  <= TD_W'(1);
          r_fidx     <= '0;
          r_type_cur <= '0;
          r_seq_cur  <= '0;
        end else if (r_state == S_TAG && w_is_dig) begin
          r_tag     <= w_tag_nxt[TAG_W-1:0];
          r_tag_dig <= r_tag_dig + TD_W'(1);
        end else if (w_fend) begin
          r_tag     <= '0;
          r_tag_dig <= '0;
          r_body_fs <= w_body_nxt;
          if (r_fidx != 2'd3)          r_fidx     <= r_fidx + 2'd1;
          if (w_t9 && r_fidx == 2'd1)  r_body_len <= r_val_num[BODYLEN_W-1:0];
          if (w_t34)                   r_seq_cur  <= r_val_num[SEQ_W-1:0];
          if (w_t35)                   r_type_cur <= w_type;
        end
        if (w_to_val) begin
          r_val_num <= '0; r_vlen <= '0; r_vfirst <= '0;
          r_nondig <= 1'b0; r_ovf_b <= 1'b0; r_ovf_s <= 1'b0;
        end else if (r_state == S_VALUE && data_i != SOH) begin
          if (r_vlen != 3'd7) r_vlen <= r_vlen + 3'd1;
          if (r_vlen == 3'd0) r_vfirst <= data_i;
          if (w_is_dig) begin
            r_val_num <= w_val_nxt[VAL_W-1:0];
            // sticky range flags; the stored value may wrap once they set
            if (w_val_nxt[VX-1:BODYLEN_W] != '0) r_ovf_b <= 1'b1;
            if (w_val_nxt[VX-1:SEQ_W] != '0)     r_ovf_s <= 1'b1;
          end else begin
            r_nondig <= 1'b1;
          end
        end
      end
    end
  end

  assign msg_valid_o = r_msg_valid;
  assign msg_type_o  = r_msg_type;
  assign seq_num_o   = r_seq;
  assign msg_error_o = r_msg_err;
  assign err_code_o  = r_err_code;
endmodule

// File: tb/tb_fix_rx_parser.sv
// Directed bench for fix_rx_parser; '|' in stimulus strings stands for SOH.
module tb_fix_rx_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        msg_valid_o, msg_error_o;
  logic [2:0]  msg_type_o, err_code_o;
  logic [31:0] seq_num_o;

  fix_rx_parser dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .msg_valid_o(msg_valid_o), .msg_type_o(msg_type_o), .seq_num_o(seq_num_o),
    .msg_error_o(msg_error_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // pulse monitor, sampled on the falling edge
  int n_val = 0, n_err = 0, n_both = 0;
  logic [2:0]  last_type = '0, prev_type = '0, last_code = '0;
  logic [31:0] last_seq = '0;
  always @(negedge clk) begin
    if (msg_valid_o) begin
      n_val++; prev_type = last_type; last_type = msg_type_o; last_seq = seq_num_o;
    end
    if (msg_error_o) begin n_err++; last_code = err_code_o; end
    if (msg_valid_o && msg_error_o) n_both++;
  end

  task automatic send(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        data_valid_i = 1'b0;
        data_i = "8";  // must be ignored while invalid
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      data_i = (s[i] == "|") ? 8'h01 : s[i];
      data_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    data_valid_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int v0, e0;
  string HB, LOGON;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HB    = "8=FIX.4.2|9=5|35=0|10=161|";
    LOGON = "8=FIX.4.2|9=10|35=A|34=1|10=180|";
    rst = 1'b1; data_i = '0; data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", msg_valid_o, 0);
    chk("rst_type",  msg_type_o, 0);
    chk("rst_seq",   seq_num_o, 0);
    chk("rst_err",   msg_error_o, 0);
    chk("rst_code",  err_code_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Heartbeat, exact timing of the pulse
    v0 = n_val; e0 = n_err;
    send(HB, 1'b0);
    chk("hb_valid_now", msg_valid_o, 1);
    chk("hb_type", msg_type_o, 2);
    chk("hb_seq",  seq_num_o, 0);
    @(posedge clk); #1;
    chk("hb_pulse_1cyc", msg_valid_o, 0);
    settle();
    chk("hb_nerr", n_err - e0, 0);

    // Logon
    v0 = n_val; e0 = n_err;
    send(LOGON, 1'b0);
    settle();
    chk("logon_nval", n_val - v0, 1);
    chk("logon_type", msg_type_o, 1);
    chk("logon_seq",  seq_num_o, 1);

    // Bad checksum
    v0 = n_val; e0 = n_err;
    send("8=FIX.4.2|9=5|35=0|10=162|", 1'b0);
    settle();
`ifdef FIX_RX_CHECKSUM_EN
    chk("ck_nerr", n_err - e0, 1);
    chk("ck_code", last_code, 5);
    chk("ck_type_hold", msg_type_o, 1);
`else
    chk("ck_nval", n_val - v0, 1);
    chk("ck_type", msg_type_o, 2);
    chk("ck_nerr", n_err - e0, 0);
`endif

    // BodyLength mismatch
    v0 = n_val; e0 = n_err;
    send("8=FIX.4.2|9=6|35=0|10=162|", 1'b0);
    settle();
    chk("len_nerr", n_err - e0, 1);
    chk("len_code", last_code, 4);

    // tag 9 missing, then resync and a good Heartbeat
    v0 = n_val; e0 = n_err;
    send("8=FIX.4.2|35=0|10=161|", 1'b0);
    send(HB, 1'b0);
    settle();
    chk("ord9_nerr", n_err - e0, 1);
    chk("ord9_code", last_code, 2);
    chk("ord9_recover_nval", n_val - v0, 1);
    chk("ord9_recover_type", msg_type_o, 2);

    // tag 8 not first
    e0 = n_err;
    send("80=X|", 1'b0); settle();
    chk("ord8_code", last_code, 1);
    // tag 35 not third
    send("8=FIX.4.2|9=5|34=1|", 1'b0); settle();
    chk("ord35_code", last_code, 3);
    // tag too long
    send("8=FIX.4.2|9=5|123456=|", 1'b0); settle();
    chk("tagovf_code", last_code, 7);
    // non-digit in tag
    send("8=FIX.4.2|9=5|3X|", 1'b0); settle();
    chk("tagfmt_code", last_code, 6);
    // empty value
    send("8=|", 1'b0); settle();
    chk("empty_code", last_code, 6);
    // MsgSeqNum above 2^32-1
    send("8=FIX.4.2|9=5|35=0|34=4294967296|", 1'b0); settle();
    chk("seqovf_code", last_code, 7);
    chk("err_batch_nerr", n_err - e0, 6);

    // Heartbeat with random gaps, then Logon back-to-back
    v0 = n_val;
    send(HB, 1'b1);
    send(LOGON, 1'b0);
    settle();
    chk("b2b_nval", n_val - v0, 2);
    chk("b2b_first", prev_type, 2);
    chk("b2b_second", last_type, 1);

    // reset mid-message
    v0 = n_val; e0 = n_err;
    send("8=FIX.4.2|9=", 1'b0);
    rst = 1'b1;
    #2;
    chk("mrst_type", msg_type_o, 0);
    chk("mrst_seq",  seq_num_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("mrst_no_pulse", (n_val - v0) + (n_err - e0), 0);
    send(HB, 1'b0);
    settle();
    chk("mrst_hb_nval", n_val - v0, 1);
    chk("mrst_hb_type", msg_type_o, 2);

    chk("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
